// File: rtl/dct_pkg.sv
// ============================================================================
// dct_pkg : shared constants and types for the DCT output buffer  (rev 1.0)
// ============================================================================
`default_nettype none

package dct_pkg;

  localparam int BLK_SIZE = 64;

  // JPEG zigzag: readout position -> raster address
  localparam logic [5:0] ZIGZAG_LUT [BLK_SIZE] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_PRIME  = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

  function automatic logic [5:0] rd_raster(input logic zigzag, input logic [5:0] k);
    return zigzag ? ZIGZAG_LUT[k] : k;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dct_obuf_ram.sv
// ============================================================================
// dct_obuf_ram : 128-entry simple dual-port RAM, registered read  (rev 1.0)
// ============================================================================
`default_nettype none

module dct_obuf_ram #(
  parameter int D_WIDTH = 13,
  parameter int AW      = 7
) (
  input  logic               clock,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);

  logic [D_WIDTH-1:0] mem [2**AW];
  logic [D_WIDTH-1:0] rd_data_q;

  // No reset so the array and read register map onto block RAM
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/dct_out_buf.sv
// ============================================================================
// dct_out_buf : ping-pong 8x8 block buffer, zigzag/raster streaming  (rev 1.0)
// ============================================================================
`default_nettype none

module dct_out_buf
  import dct_pkg::*;
#(
  parameter int D_WIDTH = 13
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               dct_flag,
  input  logic               dct_out_en,
  input  logic [5:0]         dct_out_idx,
  input  logic [D_WIDTH-1:0] dct_out_data,
  output logic               in_ready,
  output logic               ovf_err,
  output logic               blk_out_valid,
  input  logic               blk_out_ready,
  output logic [D_WIDTH-1:0] blk_out_data,
  output logic [5:0]         blk_out_idx,
  output logic               blk_out_last
);

  logic [6:0]         wr_cnt_q, wr_cnt_d;
  logic               wr_bank_q, wr_bank_d;
  logic [1:0]         full_q, full_d;
  logic               ovf_err_q, ovf_err_d;
  logic               wr_ok;

  rd_state_e          state_q, state_d;
  logic               rd_bank_q, rd_bank_d;
  logic               order_q, order_d;
  logic [6:0]         rd_k_q, rd_k_d;
  logic               rd_en;
  logic [5:0]         rd_pos;

  logic               ram_vld_q, ram_vld_d;
  logic [5:0]         ram_idx_q, ram_idx_d;
  logic               ram_last_q, ram_last_d;
  logic               skid_vld_q, skid_vld_d;
  logic [D_WIDTH-1:0] skid_data_q, skid_data_d;
  logic [5:0]         skid_idx_q, skid_idx_d;
  logic               skid_last_q, skid_last_d;
  logic [D_WIDTH-1:0] ram_rdata;

  logic               pop, head_last, last_pop;

  dct_obuf_ram #(.D_WIDTH(D_WIDTH), .AW(7)) u_ram (
    .clock   (clock),
    .wr_en   (wr_ok),
    .wr_addr ({wr_bank_q, dct_out_idx}),
    .wr_data (dct_out_data),
    .rd_en   (rd_en),
    .rd_addr ({rd_bank_q, rd_pos}),
    .rd_data (ram_rdata)
  );

  assign pop       = blk_out_valid & blk_out_ready;
  assign head_last = skid_vld_q ? skid_last_q : ram_last_q;
  assign last_pop  = pop & head_last;
  assign rd_pos    = rd_raster(order_q, rd_k_q[5:0]);

  always_comb begin
    wr_ok     = dct_out_en & ~full_q[wr_bank_q];
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    full_d    = full_q;
    ovf_err_d = ovf_err_q | (dct_out_en & full_q[wr_bank_q]);
    if (wr_ok) begin
      if (wr_cnt_q == 7'(BLK_SIZE - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + 7'd1;
      end
    end
    // A block being drained is never the current write bank while writes are accepted
    if (last_pop) full_d[rd_bank_q] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    order_d   = order_q;
    rd_en     = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = RD_PRIME;
          order_d = dct_flag;
        end
      end
      RD_PRIME: begin
        rd_en   = 1'b1;
        state_d = RD_STREAM;
      end
      RD_STREAM: begin
        // Reads stall only when both holding slots are occupied, keeping ready off the RAM path
        rd_en = (rd_k_q != 7'(BLK_SIZE)) & ~(ram_vld_q & skid_vld_q);
        if (last_pop) begin
          rd_bank_d = ~rd_bank_q;
          if (full_q[~rd_bank_q]) begin
            state_d = RD_PRIME;
            order_d = dct_flag;
          end else begin
            state_d = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase

    rd_k_d = rd_en ? rd_k_q + 7'd1 : rd_k_q;
    if (state_q == RD_IDLE || last_pop) rd_k_d = '0;
  end

  always_comb begin
    ram_vld_d   = ram_vld_q;
    ram_idx_d   = ram_idx_q;
    ram_last_d  = ram_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_idx_d  = skid_idx_q;
    skid_last_d = skid_last_q;
    if (skid_vld_q) begin
      if (pop) begin
        skid_vld_d  = ram_vld_q;
        skid_data_d = ram_rdata;
        skid_idx_d  = ram_idx_q;
        skid_last_d = ram_last_q;
        ram_vld_d   = 1'b0;
      end
    end else if (ram_vld_q) begin
      ram_vld_d = 1'b0;
      if (!pop) begin
        skid_vld_d  = 1'b1;
        skid_data_d = ram_rdata;
        skid_idx_d  = ram_idx_q;
        skid_last_d = ram_last_q;
      end
    end
    if (rd_en) begin
      ram_vld_d  = 1'b1;
      ram_idx_d  = rd_pos;
      ram_last_d = (rd_k_q == 7'(BLK_SIZE - 1));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      full_q      <= '0;
      ovf_err_q   <= 1'b0;
      state_q     <= RD_IDLE;
      rd_bank_q   <= 1'b0;
      order_q     <= 1'b0;
      rd_k_q      <= '0;
      ram_vld_q   <= 1'b0;
      ram_idx_q   <= '0;
      ram_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_idx_q  <= '0;
      skid_last_q <= 1'b0;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      full_q      <= full_d;
      ovf_err_q   <= ovf_err_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      order_q     <= order_d;
      rd_k_q      <= rd_k_d;
      ram_vld_q   <= ram_vld_d;
      ram_idx_q   <= ram_idx_d;
      ram_last_q  <= ram_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_idx_q  <= skid_idx_d;
      skid_last_q <= skid_last_d;
    end
  end

  // Skid slot holds the older beat, so it is always the head when occupied
  assign blk_out_valid = skid_vld_q | ram_vld_q;
  assign blk_out_data  = skid_vld_q ? skid_data_q : (ram_vld_q ? ram_rdata  : '0);
  assign blk_out_idx   = skid_vld_q ? skid_idx_q  : (ram_vld_q ? ram_idx_q  : '0);
  assign blk_out_last  = skid_vld_q ? skid_last_q : (ram_vld_q ? ram_last_q : 1'b0);
  assign in_ready      = ~full_q[wr_bank_q];
  assign ovf_err       = ovf_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dct_out_buf.sv
// ============================================================================
// tb_dct_out_buf : randomized self-checking bench for dct_out_buf  (rev 1.0)
// ============================================================================
`default_nettype none

module tb_dct_out_buf;

  localparam int D_WIDTH = 13;
  typedef logic [D_WIDTH+6:0] beat_t;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               dct_flag = 1'b0;
  logic               dct_out_en = 1'b0;
  logic [5:0]         dct_out_idx = '0;
  logic [D_WIDTH-1:0] dct_out_data = '0;
  logic               in_ready, ovf_err, blk_out_valid, blk_out_last;
  logic               blk_out_ready = 1'b0;
  logic [D_WIDTH-1:0] blk_out_data;
  logic [5:0]         blk_out_idx;

  dct_out_buf #(.D_WIDTH(D_WIDTH)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .dct_flag      (dct_flag),
    .dct_out_en    (dct_out_en),
    .dct_out_idx   (dct_out_idx),
    .dct_out_data  (dct_out_data),
    .in_ready      (in_ready),
    .ovf_err       (ovf_err),
    .blk_out_valid (blk_out_valid),
    .blk_out_ready (blk_out_ready),
    .blk_out_data  (blk_out_data),
    .blk_out_idx   (blk_out_idx),
    .blk_out_last  (blk_out_last)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: zigzag built by walking anti-diagonals, block contents as an array
  int                 zz_map [64];
  int                 zz_n;
  logic [D_WIDTH-1:0] blk [64];
  beat_t              exp_q [$];

  task automatic push_block(input logic zz);
    int r;
    for (int k = 0; k < 64; k++) begin
      r = zz ? zz_map[k] : k;
      exp_q.push_back({blk[r], 6'(r), (k == 63)});
    end
  endtask

  // Ready driver: 0 = always high, 1 = always low, 2 = random 50%
  int rdy_mode = 0;
  initial forever begin
    @(posedge clock);
    #1;
    case (rdy_mode)
      0:       blk_out_ready = 1'b1;
      1:       blk_out_ready = 1'b0;
      default: blk_out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: ordering against the model and stability while stalled
  int    acc_cnt = 0;
  logic  hold_q = 1'b0;
  beat_t hold_beat, cur_beat;
  initial forever begin
    @(negedge clock);
    cur_beat = {blk_out_data, blk_out_idx, blk_out_last};
    if (!reset_n) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        chk("hold_valid", 32'(blk_out_valid), 1);
        chk("hold_beat", 32'(cur_beat), 32'(hold_beat));
      end
      if (blk_out_valid && blk_out_ready) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("beat", 32'(cur_beat), 32'(exp_q.pop_front()));
        acc_cnt++;
      end
      hold_q    = blk_out_valid & ~blk_out_ready;
      hold_beat = cur_beat;
    end
  end

  task automatic wr1(input logic [5:0] idx, input logic [D_WIDTH-1:0] d);
    dct_out_en   = 1'b1;
    dct_out_idx  = idx;
    dct_out_data = d;
    @(posedge clock);
    #1;
    dct_out_en = 1'b0;
  endtask

  task automatic write_block(input logic zz, input bit seq, input bit rnd_data, input bit gaps);
    int perm [64];
    int t, j, tmp;
    t = 0;
    while (!in_ready && t < 3000) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("in_ready_wait", 32'(in_ready), 1);
    dct_flag = zz;
    for (int i = 0; i < 64; i++) perm[i] = i;
    if (!seq) begin
      for (int i = 63; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
    end
    for (int i = 0; i < 64; i++) blk[i] = rnd_data ? D_WIDTH'($urandom) : D_WIDTH'(i + 100);
    for (int i = 0; i < 64; i++) begin
      wr1(6'(perm[i]), blk[perm[i]]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
    end
    push_block(zz);
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 6000) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk(tag, 32'(exp_q.size()), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int base, t, lo, hi;
    zz_n = 0;
    for (int s = 0; s < 15; s++) begin
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 8) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_map[zz_n] = r * 8 + (s - r); zz_n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_map[zz_n] = r * 8 + (s - r); zz_n++; end
      end
    end

    // Reset values
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_ovf", 32'(ovf_err), 0);
    chk("rst_valid", 32'(blk_out_valid), 0);
    chk("rst_data", 32'(blk_out_data), 0);
    chk("rst_idx", 32'(blk_out_idx), 0);
    chk("rst_last", 32'(blk_out_last), 0);
    reset_n = 1'b1;
    idle(2);

    // Raster block with first-valid latency
    rdy_mode = 0;
    idle(1);
    base = acc_cnt;
    write_block(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock); chk("lat_cyc0", 32'(blk_out_valid), 0);
    @(negedge clock); chk("lat_cyc1", 32'(blk_out_valid), 0);
    @(negedge clock); chk("lat_cyc2", 32'(blk_out_valid), 1);
    #1;
    drain("t1_drain");
    chk("t1_beats", 32'(acc_cnt - base), 64);

    // Zigzag block
    base = acc_cnt;
    write_block(1'b1, 1'b1, 1'b0, 1'b0);
    drain("t2_drain");
    chk("t2_beats", 32'(acc_cnt - base), 64);

    // Two blocks held back, then one overflow write
    rdy_mode = 1;
    idle(1);
    base = acc_cnt;
    write_block(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_ready_after_blk1", 32'(in_ready), 1);
    write_block(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_ready_after_blk2", 32'(in_ready), 0);
    chk("t3_ovf_before", 32'(ovf_err), 0);
    wr1(6'd63, 13'h1555);
    chk("t3_ovf_set", 32'(ovf_err), 1);
    idle(5);
    chk("t3_no_beats_stalled", 32'(acc_cnt - base), 0);
    rdy_mode = 0;
    drain("t3_drain");
    chk("t3_beats", 32'(acc_cnt - base), 128);
    chk("t3_ready_after", 32'(in_ready), 1);

    // Throttled stream of three blocks; also exercises the counter after the drop
    rdy_mode = 2;
    base = acc_cnt;
    begin
      logic f;
      f = 1'($urandom_range(0, 1));
      for (int b = 0; b < 3; b++) write_block(f, 1'b0, 1'b1, 1'b1);
    end
    drain("t4_drain");
    chk("t4_beats", 32'(acc_cnt - base), 192);
    chk("t4_ovf_sticky", 32'(ovf_err), 1);

    // Flag toggle during streaming affects only the next block
    base = acc_cnt;
    write_block(1'b1, 1'b0, 1'b1, 1'b0);
    t = 0;
    while ((acc_cnt - base) < 10 && t < 2000) begin
      @(posedge clock);
      #1;
      t++;
    end
    chk("t6_progress", 32'((acc_cnt - base) >= 10), 1);
    dct_flag = 1'b0;
    drain("t6_drain_a");
    write_block(1'b0, 1'b0, 1'b1, 1'b0);
    drain("t6_drain_b");
    chk("t6_beats", 32'(acc_cnt - base), 128);

    // Reset in the middle of a readout
    rdy_mode = 0;
    base = acc_cnt;
    write_block(1'b0, 1'b1, 1'b1, 1'b0);
    t = 0;
    while ((acc_cnt - base) < 30 && t < 500) begin
      @(posedge clock);
      t++;
    end
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_valid_in_reset", 32'(blk_out_valid), 0);
    chk("t5_in_ready_reset", 32'(in_ready), 1);
    chk("t5_ovf_cleared", 32'(ovf_err), 0);
    chk("t5_last_reset", 32'(blk_out_last), 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    base = acc_cnt;
    idle(6);
    chk("t5_no_beat_after_reset", 32'(acc_cnt - base), 0);
    chk("t5_in_ready_after", 32'(in_ready), 1);
    write_block(1'b1, 1'b0, 1'b1, 1'b0);
    drain("t5_drain");
    chk("t5_beats", 32'(acc_cnt - base), 64);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

`default_nettype wire
